// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Round-robin arbiter for single-port data memory: port A single-beat
//            CPU access, port B bursts (up to MAX_BURST beats) from DMA/loader.
// Options  : DM_ARB_PERF_EN adds saturating beat/wait performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_arbiter #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH_WORDS = 128,
  parameter int MAX_BURST   = 8,
  parameter int LW          = $clog2(MAX_BURST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_valid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [LW-1:0] b_len,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_valid,
  output logic          b_done,
  output logic          err,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          MemWrite,
  input  logic [DW-1:0] dm_rdata
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_a_beats,
  output logic [31:0]   perf_b_beats,
  output logic [31:0]   perf_a_wait
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_A = 2'd1,
    ST_SERVE_B = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_b_q, rr_b_d;
  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_q;
  logic          we_b_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          a_valid_q, b_valid_q, err_q;

  logic [AW:0]   beat_addr;
  logic          beat_we;
  logic          oor;
  logic          arb;
  logic          a_eff, b_eff;

  always_comb begin
    state_d   = state_q;
    rr_b_d    = rr_b_q;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    b_done    = 1'b0;
    dm_wdata  = '0;
    beat_addr = '0;
    beat_we   = 1'b0;
    arb       = 1'b0;
    a_eff     = 1'b0;
    b_eff     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arb   = 1'b1;
        a_eff = a_req;
        b_eff = b_req;
      end
      ST_SERVE_A: begin
        a_gnt     = 1'b1;
        beat_addr = {1'b0, a_addr};
        dm_wdata  = a_wdata;
        beat_we   = a_we;
        arb       = 1'b1;
        b_eff     = b_req;
        rr_b_d    = 1'b1;
      end
      ST_SERVE_B: begin
        b_gnt     = 1'b1;
        beat_addr = {1'b0, base_q} + (AW+1)'(beat_q);
        dm_wdata  = b_wdata;
        beat_we   = we_b_q;
        b_done    = (beat_q == len_q);
        if (b_done) begin
          arb    = 1'b1;
          a_eff  = a_req;
          rr_b_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The port in its final beat still shows req this cycle; it is masked above.
    if (arb) begin
      if (a_eff && (!b_eff || !rr_b_d)) state_d = ST_SERVE_A;
      else if (b_eff)                   state_d = ST_SERVE_B;
      else                              state_d = ST_IDLE;
    end

    oor      = (state_q != ST_IDLE) && (beat_addr >= (AW+1)'(DEPTH_WORDS));
    dm_addr  = beat_addr[AW-1:0];
    MemWrite = beat_we && !oor && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_b_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      we_b_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_b_q  <= rr_b_d;
      if (state_d == ST_SERVE_B && state_q != ST_SERVE_B) begin
        base_q <= b_addr;
        len_q  <= b_len;
        we_b_q <= b_we;
        beat_q <= '0;
      end else if (state_q == ST_SERVE_B) begin
        beat_q <= beat_q + LW'(1);
      end
      a_valid_q <= a_gnt && !a_we;
      if (a_gnt && !a_we) a_rdata_q <= oor ? '0 : dm_rdata;
      b_valid_q <= b_gnt && !we_b_q;
      if (b_gnt && !we_b_q) b_rdata_q <= oor ? '0 : dm_rdata;
      err_q <= oor;
    end
  end

  assign a_rdata = a_rdata_q;
  assign a_valid = a_valid_q;
  assign b_rdata = b_rdata_q;
  assign b_valid = b_valid_q;
  assign err     = err_q;

`ifdef DM_ARB_PERF_EN
  logic [31:0] perf_a_beats_q, perf_b_beats_q, perf_a_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_a_beats_q <= '0;
      perf_b_beats_q <= '0;
      perf_a_wait_q  <= '0;
    end else begin
      if (a_gnt && perf_a_beats_q != '1)            perf_a_beats_q <= perf_a_beats_q + 32'd1;
      if (b_gnt && perf_b_beats_q != '1)            perf_b_beats_q <= perf_b_beats_q + 32'd1;
      if (a_req && !a_gnt && perf_a_wait_q != '1)   perf_a_wait_q  <= perf_a_wait_q + 32'd1;
    end
  end

  assign perf_a_beats = perf_a_beats_q;
  assign perf_b_beats = perf_b_beats_q;
  assign perf_a_wait  = perf_a_wait_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Self-checking bench for dm_arbiter with a behavioural data memory
//            and read-data scoreboards for both ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_gnt, a_valid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_valid, b_done;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [2:0]  b_len;
  logic        err, MemWrite;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
`ifdef DM_ARB_PERF_EN
  logic [31:0] perf_a_beats, perf_b_beats, perf_a_wait;
`endif

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_valid(a_valid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_valid(b_valid), .b_done(b_done),
    .err(err), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .MemWrite(MemWrite),
    .dm_rdata(dm_rdata)
`ifdef DM_ARB_PERF_EN
    , .perf_a_beats(perf_a_beats), .perf_b_beats(perf_b_beats), .perf_a_wait(perf_a_wait)
`endif
  );

  // Memory is larger than the valid range so out-of-range reads return junk.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [128];
  assign dm_rdata = mem[dm_addr[7:0]];
  always @(posedge clk) if (MemWrite) mem[dm_addr[7:0]] <= dm_wdata;

  int checks = 0, errors = 0;
  int cyc = 0, err_seen = 0, err_exp = 0, bad_we = 0, bvalid_cnt = 0;
  logic [31:0] exp_a[$], exp_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    return (addr < 32'd128) ? ref_mem[addr[6:0]] : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (a_valid) begin
      if (exp_a.size() == 0) check("a_valid_unexpected", 32'd1, 32'd0);
      else check("a_rdata_sb", a_rdata, exp_a.pop_front());
    end
    if (b_valid) begin
      bvalid_cnt++;
      if (exp_b.size() == 0) check("b_valid_unexpected", 32'd1, 32'd0);
      else check("b_rdata_sb", b_rdata, exp_b.pop_front());
    end
    if (err) err_seen++;
    if (MemWrite && dm_addr >= 32'd128) bad_we++;
  end

  task automatic idle_outputs(input string tag);
    check({tag, "_a_gnt"},   a_gnt, 0);
    check({tag, "_b_gnt"},   b_gnt, 0);
    check({tag, "_a_valid"}, a_valid, 0);
    check({tag, "_b_valid"}, b_valid, 0);
    check({tag, "_b_done"},  b_done, 0);
    check({tag, "_err"},     err, 0);
    check({tag, "_dm_addr"}, dm_addr, 0);
    check({tag, "_dm_wdata"}, dm_wdata, 0);
    check({tag, "_memwrite"}, MemWrite, 0);
  endtask

  // Called at posedge+1; returns at the negedge of the cycle after the grant.
  task automatic a_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output int gcyc);
    logic oor;
    oor = (addr >= 32'd128);
    lat = 0; gcyc = 0;
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    @(negedge clk);
    while (!a_gnt && lat < 40) begin lat++; @(negedge clk); end
    if (!a_gnt) begin
      check("a_gnt_timeout", 32'd0, 32'd1);
      a_req = 1'b0;
      return;
    end
    gcyc = cyc;
    check("a_dm_addr", dm_addr, addr);
    check("a_memwrite", MemWrite, we && !oor);
    if (we) check("a_dm_wdata", dm_wdata, data);
    else exp_a.push_back(exp_rd(addr));
    if (we && !oor) ref_mem[addr[6:0]] = data;
    if (oor) err_exp++;
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    @(negedge clk);
    check("a_valid_slot", a_valid, !we);
    check("a_err_slot", err, oor);
  endtask

  task automatic a_op(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int l, g;
    @(posedge clk); #1;
    a_access(we, addr, data, l, g);
  endtask

  // Called at posedge+1; returns at posedge+1 after the last (or aborted) beat.
  task automatic b_burst(input logic we, input logic [31:0] base, input int len,
                         input logic [31:0] d0, input int abort_beat,
                         output int first_cyc, output int last_cyc);
    int t;
    logic [31:0] addr;
    logic oor;
    t = 0; first_cyc = 0; last_cyc = 0;
    b_req = 1'b1; b_we = we; b_addr = base; b_len = 3'(len); b_wdata = d0;
    @(negedge clk);
    while (!b_gnt && t < 40) begin t++; @(negedge clk); end
    if (!b_gnt) begin
      check("b_gnt_timeout", 32'd0, 32'd1);
      b_req = 1'b0;
      return;
    end
    first_cyc = cyc;
    for (int k = 0; k <= len; k++) begin
      addr = base + 32'(k);
      oor  = (addr >= 32'd128);
      check("b_gnt", b_gnt, 1);
      check("b_dm_addr", dm_addr, addr);
      check("b_done", b_done, k == len);
      check("b_memwrite", MemWrite, we && !oor && k != abort_beat);
      if (k == abort_beat) begin
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (we) check("b_dm_wdata", dm_wdata, d0 + 32'(k));
      else exp_b.push_back(exp_rd(addr));
      if (we && !oor) ref_mem[addr[6:0]] = d0 + 32'(k);
      if (oor) err_exp++;
      last_cyc = cyc;
      @(posedge clk); #1;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_len = '0;
      b_wdata = d0 + 32'(k + 1);
      if (k + 1 == abort_beat) rst = 1'b1;
      if (k < len) @(negedge clk);
    end
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_len = '0; b_wdata = '0;
  endtask

  initial begin
    int a1l, a1c, a2l, a2c, bf, bl, lat, gc;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_len = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_outputs("reset");
    check("reset_a_rdata", a_rdata, 0);
    check("reset_b_rdata", b_rdata, 0);

    // Simultaneous requests after reset, then A contending with a full burst.
    @(posedge clk); #1;
    fork
      begin
        int t;
        t = 0;
        a_access(1'b1, 32'h40, 32'h0000_1111, a1l, a1c);
        while (!b_gnt && t < 40) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        a_access(1'b0, 32'h40, 32'h0, a2l, a2c);
      end
      b_burst(1'b1, 32'h48, 7, 32'h500, -1, bf, bl);
    join
    check("t3_a_first_lat", a1l, 1);
    check("t3_b_after_a", bf, a1c + 1);
    check("t3_a_after_burst", a2c, bl + 1);
    repeat (2) @(negedge clk);
`ifdef DM_ARB_PERF_EN
    check("perf_b_beats", perf_b_beats, 8);
    check("perf_a_beats", perf_a_beats, 2);
    check("perf_a_wait",  perf_a_wait, 8);
`endif

    // Single-beat write then read-back with latency check.
    a_op(1'b1, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    a_access(1'b0, 32'h10, 32'h0, lat, gc);
    check("t1_gnt_lat", lat, 1);
    check("t1_rdata", a_rdata, 32'hDEAD_BEEF);

    // Burst write 1..4 then burst read-back.
    @(posedge clk); #1;
    b_burst(1'b1, 32'h20, 3, 32'd1, -1, bf, bl);
    check("t2_wr_beats", bl - bf, 3);
    bvalid_cnt = 0;
    b_burst(1'b0, 32'h20, 3, 32'd0, -1, bf, bl);
    repeat (2) @(negedge clk);
    check("t2_rd_valids", bvalid_cnt, 4);
    check("t2_last_rdata", b_rdata, 4);

    // Out-of-range accesses.
    a_op(1'b1, 32'h80, 32'h1234_5678);
    @(posedge clk); #1;
    b_burst(1'b1, 32'h7E, 3, 32'h700, -1, bf, bl);
    b_burst(1'b0, 32'h7E, 3, 32'd0, -1, bf, bl);
    repeat (3) @(negedge clk);
    check("t4_err_count", err_seen, err_exp);
    check("t4_err_expected", err_exp, 5);
    check("t4_no_wrap", mem[0], 32'hA500_0000);
    check("t4_last_rdata_zero", b_rdata, 0);

    // Reset during beat 2 of a 4-beat write burst.
    @(posedge clk); #1;
    b_burst(1'b1, 32'h20, 3, 32'h100, 2, bf, bl);
    @(negedge clk);
    idle_outputs("t5_after_rst");
    check("t5_rdata_cleared", b_rdata, 0);
    check("t5_mem22_kept", mem[8'h22], 32'd3);
    check("t5_mem23_kept", mem[8'h23], 32'd4);
    a_op(1'b0, 32'h22, 32'h0);
    check("t5_read22", a_rdata, 32'd3);

    repeat (3) @(negedge clk);
    check("no_oor_writes", bad_we, 0);
    check("a_sb_drained", exp_a.size(), 0);
    check("b_sb_drained", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
